// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM behind an SPI slave: separate write/read
// address registers, optional write-address auto-increment, level-held read data.
module spi_ram_ctrl #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_SIZE = 8,
    parameter int unsigned AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [7:0]           mem_q [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_ok_q, wr_ok_d;
    logic                 rd_ok_q, rd_ok_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;
    logic                 mem_we;
    op_e                  op;

    assign op = op_e'(din[9:8]);

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_ok_d    = wr_ok_q;
        rd_ok_d    = rd_ok_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        if (rx_valid) begin
            // Any accepted command drops tx_valid; only a legal read re-raises it.
            tx_valid_d = 1'b0;
            unique case (op)
                OP_WR_ADDR: begin
                    wr_addr_d = din[ADDR_SIZE-1:0];
                    wr_ok_d   = 1'b1;
                end
                OP_WR_DATA: begin
                    if (wr_ok_q) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) begin
                            wr_addr_d = wr_addr_q + ADDR_ONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    rd_addr_d = din[ADDR_SIZE-1:0];
                    rd_ok_d   = 1'b1;
                end
                OP_RD_DATA: begin
                    if (rd_ok_q) begin
                        dout_d     = mem_q[rd_addr_q];
                        tx_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_ok_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_ok_q    <= wr_ok_d;
            rd_ok_q    <= rd_ok_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of 8-bit words in the memory array.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, giving the address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 The block SHALL have parameter AUTO_INC, default 0; when 1, the write address post-increments after each accepted write.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port din, input, 10 bits: command word from the SPI slave. Bits [9:8] are the opcode and bits [7:0] are the payload.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: din is valid and is consumed on this edge.
REQ-008 The block SHALL have port dout, output, 8 bits: read data returned to the SPI slave.
REQ-009 The block SHALL have port tx_valid, output, 1 bit: dout holds valid read data.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse flagging an illegal command sequence.

Function
REQ-011 A command SHALL be accepted only on a rising clk edge with rx_valid=1; with rx_valid=0, no register or memory location changes, except that err returns to 0.
REQ-012 Opcode 00 SHALL load wr_addr with din[ADDR_SIZE-1:0] (upper payload bits ignored) and set internal flag wr_addr_ok=1.
REQ-013 Opcode 01 with wr_addr_ok=1 SHALL write din[7:0] to mem[wr_addr] on the accepting edge.
- If AUTO_INC=1, wr_addr SHALL then increment by 1, wrapping from MEM_DEPTH-1 to 0.
REQ-014 Opcode 01 with wr_addr_ok=0 SHALL perform no write and SHALL pulse err=1 for exactly the cycle following the accepting edge.
REQ-015 Opcode 10 SHALL load rd_addr with din[ADDR_SIZE-1:0] and set internal flag rd_addr_ok=1.
REQ-016 Opcode 11 with rd_addr_ok=1 SHALL ignore din[7:0], register mem[rd_addr] into dout, and set tx_valid=1; both are visible in the cycle after the accepting edge (latency 1).
REQ-017 Opcode 11 with rd_addr_ok=0 SHALL leave dout unchanged, drive tx_valid=0, and pulse err=1 for one cycle.
REQ-018 tx_valid SHALL be level, not a pulse.
- Once set, it SHALL remain 1, and dout SHALL remain stable, until the next accepted command of any opcode.
- The SPI slave needs at least 8 cycles of stable dout to shift it out.
REQ-019 An accepted command with opcode 00, 01 or 10 SHALL clear tx_valid on its accepting edge. dout SHALL retain its last value.
REQ-020 An accepted opcode 11 arriving while tx_valid=1 SHALL reload dout from the current mem[rd_addr], and tx_valid SHALL stay 1.
REQ-021 Read and write addresses SHALL be independent registers; opcode 00 SHALL never alter rd_addr, and opcode 10 SHALL never alter wr_addr.
REQ-022 A read of an address in the same cycle it is written is impossible, because only one command is accepted per edge. A read issued on any later edge SHALL return the newly written data.
REQ-023 wr_addr_ok and rd_addr_ok SHALL stay set until reset. Once an address is loaded, repeated 01 or 11 commands without a new address SHALL be legal.
REQ-024 Memory contents SHALL be held as state with no reset, and SHALL be undefined until written.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force dout=8'h00, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_addr_ok=0 and rd_addr_ok=0.
REQ-026 Reset asserted while tx_valid=1 SHALL drop tx_valid immediately, without waiting for a clock edge.
REQ-027 After reset deasserts, the first 01 or 11 command without a preceding address command SHALL be treated as illegal per REQ-014 and REQ-017.
REQ-028 Memory contents SHALL be preserved across reset.

Verification
REQ-029 Basic write then read:
- Stimulus: after reset, send din=10'h0_2A (00), then 10'h1_5C (01), then 10'h2_2A (10), then 10'h3_00 (11), each with rx_valid=1 for one cycle.
- Required response: dout=8'h5C and tx_valid=1 one cycle after the 11 command; both held for 8 or more idle cycles.
REQ-030 Illegal sequences:
- Stimulus: after reset, send din=10'h1_FF (01).
- Required response: err=1 for one cycle and memory unchanged.
- Stimulus: then send din=10'h3_00 (11).
- Required response: err=1 for one cycle, tx_valid=0, dout=8'h00.
REQ-031 Auto-increment with wrap-around:
- Stimulus: AUTO_INC=1; send 00 with address 8'hFF, then 01 with 8'hA1, then 01 with 8'hB2.
- Required response: reading address 8'hFF returns 8'hA1, and reading address 8'h00 returns 8'hB2.
REQ-032 tx_valid clearing and back-to-back reads:
- Stimulus: with tx_valid=1, send 10 with address 8'h05.
- Required response: tx_valid=0 next cycle and dout unchanged.
- Stimulus: then send two consecutive 11 commands.
- Required response: tx_valid stays 1 across both, and dout=mem[5].
REQ-033 Reset mid-read:
- Stimulus: assert rst_n=0 asynchronously between clock edges while tx_valid=1.
- Required response: tx_valid=0 and dout=8'h00 immediately.
- Stimulus: after reset deasserts, send 10 with address 8'h2A, then 11.
- Required response: dout equals the value written to 8'h2A before the reset.
